// File: rtl/btb_pkg.sv
// Branch target buffer shared definitions: 2-bit counter encodings and
// PC-to-index / PC-to-tag helpers used by the predictor table.
package btb_pkg;

   // Two-bit saturating counter states; bit 1 is the taken prediction
   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] CTR_RESET = CTR_WNT;
   localparam logic [1:0] CTR_ALLOC = CTR_WT;

   // Table index: word-aligned PC bits just above the byte offset
   function automatic logic [63:0] btb_index(input logic [63:0] pc, input int unsigned idx_w);
      btb_index = (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   // Tag: every PC bit above the index field
   function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int unsigned idx_w);
      btb_tag = pc >> (idx_w + 32'd2);
   endfunction

endpackage

// File: rtl/btb_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module btb_sat_counter2
   import btb_pkg::*;
(
   input  logic [1:0] i_ctr,
   input  logic       i_taken,
   output logic [1:0] o_ctr_next
);

   // Saturating increment on taken, saturating decrement on not-taken
   always_comb begin
      o_ctr_next = i_ctr;
      case (i_ctr)
         CTR_SNT: o_ctr_next = i_taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: o_ctr_next = i_taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  o_ctr_next = i_taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  o_ctr_next = i_taken ? CTR_ST  : CTR_WT;
         default: o_ctr_next = CTR_RESET;
      endcase
   end

endmodule

// File: rtl/btb_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Fetch-side lookup is combinational; EX-side resolve produces the
// mispredict/flush/redirect and trains the table on the next edge.
// Optional build macro BTB_STATS_EN adds branch and mispredict counters.
module btb_branch_predictor
   import btb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int PC_W    = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic [PC_W-1:0] i_if_pc,
   output logic            o_pred_taken,
   output logic [PC_W-1:0] o_pred_target,
   input  logic            i_ex_valid,
   input  logic            i_ex_is_branch,
   input  logic [PC_W-1:0] i_ex_pc,
   input  logic            i_ex_taken,
   input  logic [PC_W-1:0] i_ex_target,
   input  logic            i_ex_pred_taken,
   input  logic [PC_W-1:0] i_ex_pred_target,
   output logic            o_mispredict,
   output logic [PC_W-1:0] o_redirect_pc,
   output logic            o_flush
`ifdef BTB_STATS_EN
   ,
   output logic [31:0]     o_stat_branches,
   output logic [31:0]     o_stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [PC_W-1:0] PC_INC = PC_W'(3'd4);

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [PC_W-1:0]    r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];

   logic [IDX_W-1:0]   w_if_idx;
   logic [TAG_W-1:0]   w_if_tag;
   logic               w_if_hit;
   logic [IDX_W-1:0]   w_ex_idx;
   logic [TAG_W-1:0]   w_ex_tag;
   logic               w_ex_hit;
   logic               w_upd_en;
   logic               w_mispredict;
   logic [1:0]         w_ctr_next;

   assign w_if_idx = IDX_W'(btb_index(64'(i_if_pc), IDX_W));
   assign w_if_tag = TAG_W'(btb_tag(64'(i_if_pc), IDX_W));
   assign w_ex_idx = IDX_W'(btb_index(64'(i_ex_pc), IDX_W));
   assign w_ex_tag = TAG_W'(btb_tag(64'(i_ex_pc), IDX_W));

   // Lookup reads the current table contents; no bypass from a same-cycle update
   assign w_if_hit      = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
   assign o_pred_taken  = w_if_hit & r_ctr[w_if_idx][1];
   assign o_pred_target = o_pred_taken ? r_target[w_if_idx] : (i_if_pc + PC_INC);

   // Wrong direction, or right "taken" direction with the wrong target; held low in reset
   assign w_mispredict  = i_rst_n & i_ex_valid & i_ex_is_branch &
                          ((i_ex_pred_taken ^ i_ex_taken) |
                           (i_ex_taken & i_ex_pred_taken & (i_ex_pred_target != i_ex_target)));
   assign o_mispredict  = w_mispredict;
   assign o_flush       = w_mispredict;
   assign o_redirect_pc = i_ex_taken ? i_ex_target : (i_ex_pc + PC_INC);

   assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
   assign w_upd_en = i_ex_valid & i_ex_is_branch & ~i_stall;

   btb_sat_counter2 u_ctr_upd (
      .i_ctr      (r_ctr[w_ex_idx]),
      .i_taken    (i_ex_taken),
      .o_ctr_next (w_ctr_next)
   );

   // Table training: counter/target update on hit, allocation on a taken miss
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_RESET;
         end
      end else if (w_upd_en) begin
         if (w_ex_hit) begin
            r_ctr[w_ex_idx] <= w_ctr_next;
            if (i_ex_taken) begin
               r_target[w_ex_idx] <= i_ex_target;
            end
         end else if (i_ex_taken) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= i_ex_target;
            r_ctr[w_ex_idx]    <= CTR_ALLOC;
         end
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   // Free-running wrap-around counts of trained branches and their mispredicts
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stat_branches    <= 32'd0;
         r_stat_mispredicts <= 32'd0;
      end else if (w_upd_en) begin
         r_stat_branches <= r_stat_branches + 32'd1;
         if (w_mispredict) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign o_stat_branches    = r_stat_branches;
   assign o_stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Directed self-checking bench for btb_branch_predictor (ENTRIES=16, PC_W=32).
module tb_btb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        flush;
`ifdef BTB_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int checks   = 0;
   int failures = 0;
   int exp_br   = 0;
   int exp_mp   = 0;

   btb_branch_predictor #(.ENTRIES(16), .PC_W(32)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_stall          (stall),
      .i_if_pc          (if_pc),
      .o_pred_taken     (pred_taken),
      .o_pred_target    (pred_target),
      .i_ex_valid       (ex_valid),
      .i_ex_is_branch   (ex_is_branch),
      .i_ex_pc          (ex_pc),
      .i_ex_taken       (ex_taken),
      .i_ex_target      (ex_target),
      .i_ex_pred_taken  (ex_pred_taken),
      .i_ex_pred_target (ex_pred_target),
      .o_mispredict     (mispredict),
      .o_redirect_pc    (redirect_pc),
      .o_flush          (flush)
`ifdef BTB_STATS_EN
      ,
      .o_stat_branches    (stat_branches),
      .o_stat_mispredicts (stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_ex(input logic v, input logic br, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
      ex_valid       = v;
      ex_is_branch   = br;
      ex_pc          = pc;
      ex_taken       = tk;
      ex_target      = tgt;
      ex_pred_taken  = ptk;
      ex_pred_target = ptgt;
   endtask

   task automatic idle();
      set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Clock one edge; mp is the hand-derived mispredict for the cycle being retired
   task automatic step(input logic mp);
      if (rst_n && ex_valid && ex_is_branch && !stall) begin
         exp_br++;
         if (mp) exp_mp++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      if_pc = pc;
      #1;
      chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
      chk({tag, "_target"}, pred_target, tgt);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      if_pc = 32'h0040_0000;
      // Branch activity during reset must neither flag nor train
      set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
      #2;
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_pred_target", pred_target, 32'h0040_0004);
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      step(1'b0);
      step(1'b0);
      rst_n = 1'b1;
      idle();
      look("post_rst_0", 32'h0040_0000, 1'b0, 32'h0040_0004);
      look("rst_discard", 32'h0040_0010, 1'b0, 32'h0040_0014);

      // First taken branch: mispredict, allocate with counter 10
      set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
      look("alloc_same_cycle", 32'h0040_0010, 1'b0, 32'h0040_0014);
      chk("alloc_mp", {31'd0, mispredict}, 32'd1);
      chk("alloc_flush", {31'd0, flush}, 32'd1);
      chk("alloc_redirect", redirect_pc, 32'h0040_0040);
      step(1'b1);
      idle();
      look("alloc_hit", 32'h0040_0010, 1'b1, 32'h0040_0040);

      // Not taken twice: 10 -> 01 -> 00
      set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
      #1;
      chk("nt1_mp", {31'd0, mispredict}, 32'd1);
      chk("nt1_redirect", redirect_pc, 32'h0040_0014);
      step(1'b1);
      idle();
      look("nt1_look", 32'h0040_0010, 1'b0, 32'h0040_0014);
      set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0040, 1'b0, 32'h0);
      #1;
      chk("nt2_mp", {31'd0, mispredict}, 32'd0);
      step(1'b0);
      idle();
      look("nt2_look", 32'h0040_0010, 1'b0, 32'h0040_0014);

      // Retrain from 00 with a new target; saturate at 11
      set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0080, 1'b0, 32'h0);
      step(1'b1);
      idle();
      look("inc_01", 32'h0040_0010, 1'b0, 32'h0040_0014);
      set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0080, 1'b0, 32'h0);
      step(1'b1);
      idle();
      look("inc_10", 32'h0040_0010, 1'b1, 32'h0040_0080);
      set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080);
      #1;
      chk("correct_mp", {31'd0, mispredict}, 32'd0);
      step(1'b0);
      step(1'b0);
      set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0080, 1'b1, 32'h0040_0080);
      step(1'b1);
      idle();
      look("sat_then_dec", 32'h0040_0010, 1'b1, 32'h0040_0080);

      // Alias on index 4 with a different tag replaces the entry
      set_ex(1'b1, 1'b1, 32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
      step(1'b1);
      idle();
      look("alias_old_miss", 32'h0040_0010, 1'b0, 32'h0040_0014);
      look("alias_new_hit", 32'h0040_0050, 1'b1, 32'h0040_0100);

      // Stall: flags still raised, table untouched
      stall = 1'b1;
      set_ex(1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
      #1;
      chk("stall_mp", {31'd0, mispredict}, 32'd1);
      chk("stall_flush", {31'd0, flush}, 32'd1);
      step(1'b1);
      set_ex(1'b1, 1'b1, 32'h0040_0050, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
      step(1'b1);
      stall = 1'b0;
      idle();
      look("stall_no_alloc", 32'h0040_0020, 1'b0, 32'h0040_0024);
      look("stall_no_dec", 32'h0040_0050, 1'b1, 32'h0040_0100);

      // Same-cycle lookup and update: old value now, new value next cycle
      set_ex(1'b1, 1'b1, 32'h0040_0050, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
      look("rbw_old", 32'h0040_0050, 1'b1, 32'h0040_0100);
      step(1'b1);
      idle();
      look("rbw_new", 32'h0040_0050, 1'b0, 32'h0040_0054);

      // Target mismatch with correct direction, bubble and non-branch qualifiers
      set_ex(1'b1, 1'b1, 32'h0040_0050, 1'b1, 32'h0040_0104, 1'b1, 32'h0040_0100);
      #1;
      chk("tgt_mismatch_mp", {31'd0, mispredict}, 32'd1);
      chk("tgt_mismatch_redirect", redirect_pc, 32'h0040_0104);
      ex_valid = 1'b0;
      #1;
      chk("bubble_mp", {31'd0, mispredict}, 32'd0);
      ex_valid     = 1'b1;
      ex_is_branch = 1'b0;
      #1;
      chk("nonbranch_mp", {31'd0, flush}, 32'd0);
      idle();

      // PC+4 wrap at the top of the address space
      look("wrap_pred", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
      set_ex(1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("wrap_redirect", redirect_pc, 32'h0000_0000);
      idle();
      step(1'b0);

`ifdef BTB_STATS_EN
      chk("stat_branches", stat_branches, 32'(exp_br));
      chk("stat_mispredicts", stat_mispredicts, 32'(exp_mp));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
